// File: rtl/sustained_req_rr_arbiter.sv
// sustained_req_rr_arbiter
// Round-robin arbiter that only grants requesters whose request has been
// held high for HOLD consecutive samples. Each grant lasts at most
// MAX_GRANT cycles and is followed by a one-cycle cool-down. The released
// owner must requalify from zero before it can win again.
module sustained_req_rr_arbiter #(
  parameter int N         = 4,
  parameter int HOLD      = 3,
  parameter int MAX_GRANT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         qual,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(HOLD + 1);
  localparam int TW = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [CW-1:0]   cnt_q [N];
  logic [CW-1:0]   cnt_d [N];

  logic            found;
  logic [IW-1:0]   pick;
  logic            end_grant;
  logic            rel;

  // Saturating increment of a qualification counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CW'(HOLD)) sat_inc = v;
    else                sat_inc = v + CW'(1);
  endfunction

  // Requester index following i, wrapping at N.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IW'(N - 1)) next_idx = '0;
    else                 next_idx = i + IW'(1);
  endfunction

  // One-hot vector with bit i set.
  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Qualified flags decoded straight from the counter registers.
  always_comb begin
    qual = '0;
    for (int i = 0; i < N; i++) begin
      qual[i] = (cnt_q[i] == CW'(HOLD));
    end
  end

  // Pick the first qualified requester scanning from ptr upward, wrapping.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      idx  = (int'(ptr_q) + k) % N;
      cand = IW'(idx);
      if (!found && qual[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // A grant ends when the owner drops its request or the length limit is hit;
  // both causes collapse into the same release.
  assign end_grant = !req[id_q] || (tcnt_q == TW'(MAX_GRANT - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = GRANT;
      GRANT:   if (end_grant) state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: next grant vector, owner id, grant timer, pointer, release strobe.
  always_comb begin
    gnt_d  = gnt_q;
    id_d   = id_q;
    tcnt_d = tcnt_q;
    ptr_d  = ptr_q;
    rel    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d  = onehot(pick);
          id_d   = pick;
          tcnt_d = '0;
        end
      end
      GRANT: begin
        if (end_grant) begin
          gnt_d = '0;
          rel   = 1'b1;
          ptr_d = next_idx(id_q);
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: gnt_d = '0;
    endcase
  end

  // Qualification counters; the released owner is forced back to zero.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = req[i] ? sat_inc(cnt_q[i]) : '0;
      if (rel && (id_q == IW'(i))) cnt_d[i] = '0;
    end
  end

  // Grant, owner, timer, pointer and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q  <= '0;
      id_q   <= '0;
      tcnt_q <= '0;
      ptr_q  <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      gnt_q  <= gnt_d;
      id_q   <= id_d;
      tcnt_q <= tcnt_d;
      ptr_q  <= ptr_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign busy   = (state_q != IDLE);

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));
  a_gnt_in_grant : assert property (@(posedge clk) disable iff (!rst)
                                    (gnt_q != '0) |-> (state_q == GRANT));
  a_busy_state : assert property (@(posedge clk) disable iff (!rst)
                                  busy == (state_q != IDLE));

endmodule

// File: tb/tb_sustained_req_rr_arbiter.sv
// Bench for sustained_req_rr_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a run-length model.
module tb_sustained_req_rr_arbiter;

  localparam int N         = 4;
  localparam int HOLD      = 3;
  localparam int MAX_GRANT = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] qual;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;

  int checks = 0;
  int fails  = 0;
  int ecount = 0;

  sustained_req_rr_arbiter #(.N(N), .HOLD(HOLD), .MAX_GRANT(MAX_GRANT)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .qual   (qual),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: run lengths, owner, phase ----------------
  int m_run [N];
  int m_owner, m_id, m_phase, m_age, m_ptr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) m_run[i] <= 0;
      m_owner <= 0;
      m_id    <= 0;
      m_phase <= 0;
      m_age   <= 0;
      m_ptr   <= 0;
    end else begin : step
      int own, ph, ag, pt, id, k;
      bit rel;
      own = m_owner; ph = m_phase; ag = m_age; pt = m_ptr; id = m_id; rel = 0; k = 0;
      if (m_phase == 0) begin
        for (int s = 0; s < N; s++) begin
          k = (m_ptr + s) % N;
          if (ph == 0 && m_run[k] >= HOLD) begin
            own = k; id = k; ag = 1; ph = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (!req[m_owner] || m_age == MAX_GRANT) begin
          rel = 1; pt = (m_owner + 1) % N; ph = 2;
        end else begin
          ag = m_age + 1;
        end
      end else begin
        ph = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (rel && i == m_owner) m_run[i] <= 0;
        else if (req[i])         m_run[i] <= (m_run[i] >= HOLD) ? HOLD : m_run[i] + 1;
        else                     m_run[i] <= 0;
      end
      m_owner <= own; m_phase <= ph; m_age <= ag; m_ptr <= pt; m_id <= id;
    end
  end

  function automatic int m_qual();
    int q = 0;
    for (int i = 0; i < N; i++) if (m_run[i] >= HOLD) q |= (1 << i);
    return q;
  endfunction

  // Per-cycle comparison on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    chk("model_qual",   int'(qual),   m_qual());
    chk("model_gnt",    int'(gnt),    (m_phase == 1) ? (1 << m_owner) : 0);
    chk("model_gnt_id", int'(gnt_id), m_id);
    chk("model_busy",   int'(busy),   (m_phase != 0) ? 1 : 0);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic to_edge(input int k);
    while (ecount < k) tick();
  endtask

  task automatic start(input logic [N-1:0] r);
    rst = 1'b0;
    req = r;
    tick();
    rst    = 1'b1;
    ecount = 0;
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b1111;
    repeat (3) tick();
    chk("rst_gnt",    int'(gnt),    0);
    chk("rst_qual",   int'(qual),   0);
    chk("rst_busy",   int'(busy),   0);
    chk("rst_gnt_id", int'(gnt_id), 0);

    // single sustained requester with timeout and requalification
    start(4'b0001);
    to_edge(2);  chk("s_qual_e2", int'(qual), 0);
    to_edge(3);  chk("s_qual_e3", int'(qual), 1); chk("s_gnt_e3", int'(gnt), 0);
    to_edge(4);  chk("s_gnt_e4", int'(gnt), 1); chk("s_busy_e4", int'(busy), 1);
    to_edge(11); chk("s_gnt_e11", int'(gnt), 1);
    to_edge(12); chk("s_gnt_e12", int'(gnt), 0); chk("s_busy_e12", int'(busy), 1);
    to_edge(13); chk("s_busy_e13", int'(busy), 0);
    to_edge(14); chk("s_qual_e14", int'(qual), 0);
    to_edge(15); chk("s_qual_e15", int'(qual), 1);
    to_edge(16); chk("s_gnt_e16", int'(gnt), 1);

    // glitch rejection on req[2]
    start(4'b0100);
    for (int e = 1; e <= 12; e++) begin
      to_edge(e);
      if (e == 2) req = 4'b0000;
      if (e == 3) req = 4'b0100;
      if (e == 5) req = 4'b0000;
      chk("g_qual2", int'(qual[2]), 0);
      chk("g_gnt",   int'(gnt),     0);
      chk("g_busy",  int'(busy),    0);
    end

    // round robin with all requesters held
    start(4'b1111);
    for (int j = 0; j < 5; j++) begin
      to_edge(4 + 10 * j);  chk("rr_gnt_start", int'(gnt), 1 << (j % 4));
                            chk("rr_id",        int'(gnt_id), j % 4);
      to_edge(11 + 10 * j); chk("rr_gnt_last",  int'(gnt), 1 << (j % 4));
      to_edge(12 + 10 * j); chk("rr_gap1",      int'(gnt), 0);
      to_edge(13 + 10 * j); chk("rr_gap2",      int'(gnt), 0);
                            chk("rr_idle",      int'(busy), 0);
    end

    // early release, then pointer moves past the released owner
    start(4'b0100);
    to_edge(4);  chk("e_gnt_e4", int'(gnt), 4'b0100);
    to_edge(6);  req = 4'b0000;
    to_edge(7);  chk("e_gnt_e7", int'(gnt), 0); chk("e_busy_e7", int'(busy), 1);
    to_edge(8);  chk("e_busy_e8", int'(busy), 0); chk("e_id_e8", int'(gnt_id), 2);
    req = 4'b1001;
    to_edge(11); chk("e_qual_e11", int'(qual), 4'b1001); chk("e_gnt_e11", int'(gnt), 0);
    to_edge(12); chk("e_gnt_e12", int'(gnt), 4'b1000); chk("e_id_e12", int'(gnt_id), 3);

    // asynchronous reset in the middle of a grant
    start(4'b0010);
    to_edge(4);  chk("m_gnt_e4", int'(gnt), 4'b0010);
    #2;
    rst = 1'b0;
    #1;
    chk("m_async_gnt",  int'(gnt),    0);
    chk("m_async_busy", int'(busy),   0);
    chk("m_async_qual", int'(qual),   0);
    chk("m_async_id",   int'(gnt_id), 0);
    start(4'b0010);
    to_edge(3);  chk("m_qual_e3", int'(qual), 4'b0010); chk("m_gnt_e3", int'(gnt), 0);
    to_edge(4);  chk("m_gnt_e4b", int'(gnt), 4'b0010);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sustained_req_rr_arbiter.md
# sustained_req_rr_arbiter

Round-robin arbiter that grants a shared resource only to requesters whose request has been held high for HOLD consecutive cycles, reusing the team's "N-cycles-high" qualification scheme per requester. It sits between several request sources and one shared resource or datapath. It sequences ownership with a bounded grant length and a one-cycle cool-down between owners, and forces each released owner to requalify.

## Interface
- N, 4, number of requesters (≥2)
- HOLD, 3, consecutive high samples of req[i] needed to qualify (≥1)
- MAX_GRANT, 8, maximum cycles a grant may last (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  N  per-requester request level
- qual  output  N  registered per-requester "held HOLD cycles" flag
- gnt  output  N  one-hot grant, registered; all zero when no owner
- gnt_id  output  clog2(N)  index of current/last owner
- busy  output  1  high in GRANT or COOL

## Operation
- Qualification counters: one saturating counter cnt[i] per requester, width clog2(HOLD+1).
  - req[i]=0 sampled → cnt[i]=0.
  - req[i]=1 sampled → cnt[i]+1, saturating at HOLD.
  - qual[i] = (cnt[i]==HOLD), taken from the register.
- State machine: IDLE, GRANT, COOL.
  - IDLE: if any qual bit is set, select the first set bit scanning ptr, ptr+1, … mod N. Load owner, gnt=onehot(owner), gnt_id=owner, tcnt=0, go to GRANT. Otherwise stay in IDLE.
  - GRANT: if req[owner] is sampled 0, or tcnt==MAX_GRANT-1, go to COOL with gnt=0. Otherwise tcnt+1.
  - GRANT → COOL edge: ptr = (owner+1) mod N, and cnt[owner] is forced to 0, even if req is still high.
  - COOL: exactly one cycle, gnt=0, then go to IDLE.
- Counters of non-owners run in every state. The owner's counter also runs during GRANT, but the release clears it.
- gnt_id holds the last owner through COOL and IDLE.
- Round-robin pointer ptr: reset 0, updated only on release.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, ptr=0, all cnt=0, qual=0, gnt=0, gnt_id=0, busy=0. Outputs clear immediately, without waiting for a clock edge.
- Qualification latency: req[i] sampled high on edges k-HOLD+1..k → qual[i]=1 after edge k.
- Grant latency from IDLE: gnt is set after edge k+1. Total is HOLD+1 edges from the first high sample.
- Grant length: at most MAX_GRANT cycles.
- Early release: gnt drops after the first edge that samples req[owner]=0.
- Gap between owners: gnt stays all-zero for at least 2 cycles (COOL, then IDLE).
- Simultaneous timeout and req drop on the same edge: a single transition to COOL. The result is identical to either cause alone.
- A requester that qualifies during GRANT or COOL waits in qual=1. It is considered at the IDLE edge.
- A req[i] drop anywhere clears cnt[i] and qual[i] on that edge.
- HOLD=1: qual follows req with 1-edge latency.
- MAX_GRANT=1: every grant lasts exactly 1 cycle.
- Reset mid-grant: gnt falls asynchronously. After rst is released, qualification restarts from 0.
- Invariants, checked by assertions:
  - $onehot0(gnt).
  - gnt≠0 only in GRANT.
  - busy==(state≠IDLE).

## Test plan
(All scenarios use N=4, HOLD=3, MAX_GRANT=8. Edge 1 is the first edge after rst is released.)
- Reset: hold rst=0 with req=1111 → gnt=0000, qual=0000, busy=0, gnt_id=0. An rst=0 pulse between edges clears outputs immediately.
- Single sustained requester: req=0001 from edge 1, held.
  - qual[0]=1 after edge 3; gnt=0001 after edge 4.
  - gnt=0000 after edge 12 (timeout).
  - Requalification: qual[0]=1 after edge 15; gnt=0001 again after edge 16.
- Glitch rejection: req[2] high for 2 samples, low 1, high 2, low → qual[2] never 1, gnt stays 0000, busy stays 0.
- Round robin: req=1111 held from edge 1.
  - Grant order is 0,1,2,3,0.
  - Each grant lasts 8 cycles, with exactly 2 gnt=0000 cycles between grants.
  - gnt_id sequence is 0,1,2,3,0.
- Early release: req=0100 held.
  - gnt=0100 after edge 4; req[2] deasserted before edge 7.
  - gnt=0000 after edge 7, busy=0 after edge 8, ptr=3.
  - Then req=1001 held → next grant is 1000 (id 3).
- Mid-grant reset: during gnt=0010, drive rst=0 → gnt=0000 immediately. After release with req=0010 held, gnt=0010 re-asserts after edge 4.
